// File: rtl/ahb_slave_resp_mux.sv
// AHB-Lite data-phase response multiplexer with built-in default slave.
// Registers the address-phase slave select and steers HRDATA/HREADY/HRESP back to the master.
module ahb_slave_resp_mux #(
  parameter int NSLV = 4,
  parameter int DW   = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic [NSLV-1:0]      HSEL_in,
  input  logic                 HSEL_DEF,
  input  logic [1:0]           HTRANS,
  input  logic [NSLV*DW-1:0]   HRDATA_S,
  input  logic [NSLV-1:0]      HREADYOUT_S,
  input  logic [NSLV-1:0]      HRESP_S,
  output logic [DW-1:0]        HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [NSLV-1:0]      DSEL,
  output logic                 SEL_ERR
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t          state_q, state_d;
  logic [NSLV-1:0] dsel_q, dsel_d;
  logic            sel_err_q, sel_err_d;

  logic [NSLV-1:0] sel_onehot;
  logic            sel_multi, sel_conflict, def_req, capture;
  logic [DW-1:0]   mux_data;
  logic            mux_rdy, mux_resp;

  // Isolate the lowest set bit so a multi-hot select still picks exactly one slave.
  assign sel_onehot   = HSEL_in & (~HSEL_in + NSLV'(1));
  assign sel_multi    = |(HSEL_in & ~sel_onehot);
  assign sel_conflict = HSEL_DEF & (|HSEL_in);
  // A real slave select always overrides the default slave.
  assign def_req      = HSEL_DEF & (HTRANS inside {2'b10, 2'b11}) & ~(|HSEL_in);
  assign capture      = HREADY;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      dsel_q    <= '0;
      sel_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dsel_q    <= dsel_d;
      sel_err_q <= sel_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dsel_d    = capture ? sel_onehot : dsel_q;
    sel_err_d = sel_err_q | (capture & (sel_multi | sel_conflict));
    case (state_q)
      ST_IDLE: if (capture && def_req) state_d = ST_ERR1;
      ST_ERR1: state_d = ST_ERR2;
      // ERR2 drives HREADY high, so it doubles as the next address-phase capture.
      ST_ERR2: state_d = (capture && def_req) ? ST_ERR1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mux_data = '0;
    mux_rdy  = 1'b0;
    mux_resp = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (dsel_q[i]) begin
        mux_data = HRDATA_S[i*DW +: DW];
        mux_rdy  = HREADYOUT_S[i];
        mux_resp = HRESP_S[i];
      end
    end
  end

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (state_q)
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      ST_ERR2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        if (|dsel_q) begin
          HRDATA = mux_data;
          HREADY = mux_rdy;
          HRESP  = mux_resp;
        end
      end
    endcase
  end

  assign DSEL    = dsel_q;
  assign SEL_ERR = sel_err_q;

endmodule

// File: tb/tb_ahb_slave_resp_mux.sv
// Directed, table-driven bench for ahb_slave_resp_mux (NSLV=4, DW=32).
module tb_ahb_slave_resp_mux;

  localparam int NSLV = 4;
  localparam int DW   = 32;

  logic                HCLK = 1'b0;
  logic                HRESET;
  logic [NSLV-1:0]     HSEL_in;
  logic                HSEL_DEF;
  logic [1:0]          HTRANS;
  logic [NSLV*DW-1:0]  HRDATA_S;
  logic [NSLV-1:0]     HREADYOUT_S;
  logic [NSLV-1:0]     HRESP_S;
  logic [DW-1:0]       HRDATA;
  logic                HREADY;
  logic                HRESP;
  logic [NSLV-1:0]     DSEL;
  logic                SEL_ERR;

  ahb_slave_resp_mux #(.NSLV(NSLV), .DW(DW)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL_in     (HSEL_in),
    .HSEL_DEF    (HSEL_DEF),
    .HTRANS      (HTRANS),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .DSEL        (DSEL),
    .SEL_ERR     (SEL_ERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [3:0]  hsel;
    logic        def;
    logic [1:0]  trans;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic        e_rdy;
    logic        e_resp;
    logic [31:0] e_data;
    logic [3:0]  e_dsel;
    logic        e_err;
  } vec_t;

  localparam int NVEC = 17;
  vec_t tbl [NVEC];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic e_rdy, input logic e_resp,
                         input logic [31:0] e_data, input logic [3:0] e_dsel, input logic e_err);
    chk({tag, ".HREADY"},  {31'd0, HREADY},  {31'd0, e_rdy});
    chk({tag, ".HRESP"},   {31'd0, HRESP},   {31'd0, e_resp});
    chk({tag, ".HRDATA"},  HRDATA,           e_data);
    chk({tag, ".DSEL"},    {28'd0, DSEL},    {28'd0, e_dsel});
    chk({tag, ".SEL_ERR"}, {31'd0, SEL_ERR}, {31'd0, e_err});
    $display("%s: hready=%0b hresp=%0b hrdata=%h dsel=%b sel_err=%0b",
             tag, HREADY, HRESP, HRDATA, DSEL, SEL_ERR);
  endtask

  initial begin
    // Each row: inputs driven mid-cycle, outputs expected in that same cycle.
    tbl[0]  = '{4'b0010, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0};
    tbl[1]  = '{4'b0100, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'hCAFE_0001, 4'b0010, 1'b0};
    tbl[2]  = '{4'b0001, 1'b0, 2'b10, 4'b1011, 4'b0000, 1'b0, 1'b0, 32'hCAFE_0002, 4'b0100, 1'b0};
    tbl[3]  = '{4'b0001, 1'b0, 2'b10, 4'b1011, 4'b0000, 1'b0, 1'b0, 32'hCAFE_0002, 4'b0100, 1'b0};
    tbl[4]  = '{4'b0001, 1'b0, 2'b10, 4'b1011, 4'b0000, 1'b0, 1'b0, 32'hCAFE_0002, 4'b0100, 1'b0};
    tbl[5]  = '{4'b0001, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'hCAFE_0002, 4'b0100, 1'b0};
    tbl[6]  = '{4'b0000, 1'b1, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'hCAFE_0000, 4'b0001, 1'b0};
    tbl[7]  = '{4'b0000, 1'b1, 2'b10, 4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0,         4'b0000, 1'b0};
    tbl[8]  = '{4'b0000, 1'b1, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b1, 32'h0,         4'b0000, 1'b0};
    tbl[9]  = '{4'b0000, 1'b0, 2'b00, 4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0,         4'b0000, 1'b0};
    tbl[10] = '{4'b0000, 1'b1, 2'b00, 4'b1111, 4'b0000, 1'b1, 1'b1, 32'h0,         4'b0000, 1'b0};
    tbl[11] = '{4'b0000, 1'b1, 2'b00, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0};
    tbl[12] = '{4'b0110, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b0};
    tbl[13] = '{4'b0001, 1'b1, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'hCAFE_0001, 4'b0010, 1'b1};
    tbl[14] = '{4'b0001, 1'b0, 2'b10, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'hCAFE_0000, 4'b0001, 1'b1};
    tbl[15] = '{4'b0000, 1'b0, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b1, 32'hCAFE_0000, 4'b0001, 1'b1};
    tbl[16] = '{4'b0000, 1'b0, 2'b00, 4'b1111, 4'b0001, 1'b1, 1'b0, 32'h0,         4'b0000, 1'b1};

    for (int i = 0; i < NSLV; i++) HRDATA_S[i*DW +: DW] = 32'hCAFE_0000 | i;
    HRESET      = 1'b1;
    HSEL_in     = '0;
    HSEL_DEF    = 1'b0;
    HTRANS      = 2'b00;
    HREADYOUT_S = 4'b1111;
    HRESP_S     = 4'b0000;

    #2;
    chk_all("reset", 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      @(negedge HCLK);
      HSEL_in     = tbl[v].hsel;
      HSEL_DEF    = tbl[v].def;
      HTRANS      = tbl[v].trans;
      HREADYOUT_S = tbl[v].rdy;
      HRESP_S     = tbl[v].rsp;
      #1;
      chk_all($sformatf("vec%0d", v), tbl[v].e_rdy, tbl[v].e_resp,
              tbl[v].e_data, tbl[v].e_dsel, tbl[v].e_err);
    end

    // Asynchronous reset landing in the middle of ERR1.
    @(negedge HCLK);
    HSEL_in  = 4'b0000;
    HSEL_DEF = 1'b1;
    HTRANS   = 2'b10;
    HRESP_S  = 4'b0000;
    @(posedge HCLK);
    #2;
    HSEL_DEF = 1'b0;
    HTRANS   = 2'b00;
    chk_all("err1_pre_rst", 1'b0, 1'b1, 32'h0, 4'b0000, 1'b1);
    HRESET = 1'b1;
    #1;
    chk_all("err1_async_rst", 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    #1;
    chk_all("post_rst_idle", 1'b1, 1'b0, 32'h0, 4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
